// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster-timing constants and helpers for the VGA sync generator.
// Defaults describe 800x600@60 (40 MHz pixel clock). The helpers derive axis
// totals and sync-region bounds from the four per-axis segment lengths, so
// the top level and the axis counters agree on the same arithmetic.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Sum of the four segments of one axis (active, front porch, sync, back porch).
  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // First count of the sync pulse: sync starts right after the front porch.
  function automatic int sync_first(input int act, input int fp);
    return act + fp;
  endfunction

  // Last count of the sync pulse (inclusive).
  function automatic int sync_last(input int act, input int fp, input int sync);
    return act + fp + sync - 1;
  endfunction

  // 800x600@60 horizontal timing (pixels)
  localparam int H_PIXELS_DEF     = 800;
  localparam int H_FRONTPORCH_DEF = 40;
  localparam int H_SYNCTIME_DEF   = 128;
  localparam int H_BACKPORCH_DEF  = 88;

  // 800x600@60 vertical timing (lines)
  localparam int V_LINES_DEF      = 600;
  localparam int V_FRONTPORCH_DEF = 1;
  localparam int V_SYNCTIME_DEF   = 4;
  localparam int V_BACKPORCH_DEF  = 23;

  localparam int CNT_BITS_DEF     = 11;

  // Derived totals: 1056 pixels per line, 628 lines per frame
  localparam int H_TOTAL_DEF = axis_total(H_PIXELS_DEF, H_FRONTPORCH_DEF,
                                          H_SYNCTIME_DEF, H_BACKPORCH_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_LINES_DEF, V_FRONTPORCH_DEF,
                                          V_SYNCTIME_DEF, V_BACKPORCH_DEF);

  // Sync-region bounds: pixels 840..967, lines 601..604
  localparam int H_SYNC_FIRST_DEF = sync_first(H_PIXELS_DEF, H_FRONTPORCH_DEF);
  localparam int H_SYNC_LAST_DEF  = sync_last(H_PIXELS_DEF, H_FRONTPORCH_DEF, H_SYNCTIME_DEF);
  localparam int V_SYNC_FIRST_DEF = sync_first(V_LINES_DEF, V_FRONTPORCH_DEF);
  localparam int V_SYNC_LAST_DEF  = sync_last(V_LINES_DEF, V_FRONTPORCH_DEF, V_SYNCTIME_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a modulo-TOTAL counter plus region decode.
// Ports:
//   clk_pll   in   pixel clock
//   rst       in   asynchronous active-low reset
//   step      in   advance the counter this cycle
//   count     out  current count, 0..TOTAL-1
//   wrap      out  count is at its last value (next step returns to 0)
//   in_sync   out  count lies inside the sync pulse
//   in_active out  count lies inside the visible region
// Region flags are decoded combinationally from the count; the top level
// registers them together with the count so everything stays aligned.
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = H_PIXELS_DEF,
  parameter int FP       = H_FRONTPORCH_DEF,
  parameter int SYNC     = H_SYNCTIME_DEF,
  parameter int BP       = H_BACKPORCH_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk_pll,
  input  logic                rst,
  input  logic                step,
  output logic [CNT_BITS-1:0] count,
  output logic                wrap,
  output logic                in_sync,
  output logic                in_active
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_BITS-1:0] ZERO_C    = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] ONE_C     = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] LAST_C    = CNT_BITS'(TOTAL - 1);
  localparam logic [CNT_BITS-1:0] SYNC_LO_C = CNT_BITS'(sync_first(ACTIVE, FP));
  localparam logic [CNT_BITS-1:0] SYNC_HI_C = CNT_BITS'(sync_last(ACTIVE, FP, SYNC));
  localparam logic [CNT_BITS-1:0] ACT_END_C = CNT_BITS'(ACTIVE);

  logic [CNT_BITS-1:0] count_r;

  // Axis counter: advances on step, wraps from TOTAL-1 back to 0, holds otherwise.
  always_ff @(posedge clk_pll or negedge rst) begin
    if (!rst) begin
      count_r <= ZERO_C;
    end else if (step) begin
      if (count_r == LAST_C) begin
        count_r <= ZERO_C;
      end else begin
        count_r <= count_r + ONE_C;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Region decode of the current count.
  always_comb begin
    count     = count_r;
    wrap      = (count_r == LAST_C);
    in_sync   = (count_r >= SYNC_LO_C) && (count_r <= SYNC_HI_C);
    in_active = (count_r < ACT_END_C);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Raster timing generator feeding the pixel/colour generator. Produces
// HSYNC/VSYNC, an active-video qualifier, pixel coordinates and line/frame
// strobes from the pixel clock. All outputs are registered one cycle after
// the internal counters and are mutually aligned.
// Ports:
//   clk_pll     in   pixel clock
//   rst         in   asynchronous active-low reset
//   en          in   pixel clock enable; counters and outputs advance only when 1
//   hsync       out  horizontal sync (asserted level = H_SYNC_POL)
//   vsync       out  vertical sync   (asserted level = V_SYNC_POL)
//   active      out  coordinates lie in the visible area
//   pixel_x     out  horizontal count
//   pixel_y     out  vertical count
//   line_start  out  one-cycle strobe for pixel_x = 0
//   frame_start out  one-cycle strobe for pixel_x = 0, pixel_y = 0
//   frame_cnt   out  frame counter
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to enable the 8-bit frame
// counter; without it frame_cnt is tied to zero.
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_PIXELS     = H_PIXELS_DEF,
  parameter int H_FRONTPORCH = H_FRONTPORCH_DEF,
  parameter int H_SYNCTIME   = H_SYNCTIME_DEF,
  parameter int H_BACKPORCH  = H_BACKPORCH_DEF,
  parameter int V_LINES      = V_LINES_DEF,
  parameter int V_FRONTPORCH = V_FRONTPORCH_DEF,
  parameter int V_SYNCTIME   = V_SYNCTIME_DEF,
  parameter int V_BACKPORCH  = V_BACKPORCH_DEF,
  parameter bit H_SYNC_POL   = 1'b1,
  parameter bit V_SYNC_POL   = 1'b1,
  parameter int CNT_BITS     = CNT_BITS_DEF
) (
  input  logic                clk_pll,
  input  logic                rst,
  input  logic                en,
  output logic                hsync,
  output logic                vsync,
  output logic                active,
  output logic [CNT_BITS-1:0] pixel_x,
  output logic [CNT_BITS-1:0] pixel_y,
  output logic                line_start,
  output logic                frame_start,
  output logic [7:0]          frame_cnt
);

  localparam logic [CNT_BITS-1:0] ZERO_C = {CNT_BITS{1'b0}};

  logic [CNT_BITS-1:0] h_count_s;
  logic [CNT_BITS-1:0] v_count_s;
  logic                h_wrap_s;
  logic                h_sync_s;
  logic                h_active_s;
  logic                v_wrap_unused_s;
  logic                v_sync_s;
  logic                v_active_s;
  logic                v_step_s;
  logic                line_origin_s;
  logic                frame_origin_s;

  // The vertical axis only moves on the enabled cycle that ends a line.
  assign v_step_s       = en & h_wrap_s;
  assign line_origin_s  = (h_count_s == ZERO_C);
  assign frame_origin_s = line_origin_s && (v_count_s == ZERO_C);

  vga_axis_counter #(
    .ACTIVE   (H_PIXELS),
    .FP       (H_FRONTPORCH),
    .SYNC     (H_SYNCTIME),
    .BP       (H_BACKPORCH),
    .CNT_BITS (CNT_BITS)
  ) u_h_axis (
    .clk_pll   (clk_pll),
    .rst       (rst),
    .step      (en),
    .count     (h_count_s),
    .wrap      (h_wrap_s),
    .in_sync   (h_sync_s),
    .in_active (h_active_s)
  );

  vga_axis_counter #(
    .ACTIVE   (V_LINES),
    .FP       (V_FRONTPORCH),
    .SYNC     (V_SYNCTIME),
    .BP       (V_BACKPORCH),
    .CNT_BITS (CNT_BITS)
  ) u_v_axis (
    .clk_pll   (clk_pll),
    .rst       (rst),
    .step      (v_step_s),
    .count     (v_count_s),
    .wrap      (v_wrap_unused_s),
    .in_sync   (v_sync_s),
    .in_active (v_active_s)
  );

  // Output register: loads the decoded counter state on enabled cycles; strobes drop otherwise.
  always_ff @(posedge clk_pll or negedge rst) begin
    if (!rst) begin
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      active      <= 1'b0;
      pixel_x     <= ZERO_C;
      pixel_y     <= ZERO_C;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= h_sync_s ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= v_sync_s ? V_SYNC_POL : ~V_SYNC_POL;
      active      <= h_active_s & v_active_s;
      pixel_x     <= h_count_s;
      pixel_y     <= v_count_s;
      line_start  <= line_origin_s;
      frame_start <= frame_origin_s;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic       frame_seen_r;
  logic [7:0] frame_cnt_r;

  // Frame counter: the first frame after reset reads 0, each later frame start adds one (mod 256).
  always_ff @(posedge clk_pll or negedge rst) begin
    if (!rst) begin
      frame_seen_r <= 1'b0;
      frame_cnt_r  <= 8'd0;
    end else if (en && frame_origin_s) begin
      frame_seen_r <= 1'b1;
      if (frame_seen_r) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end else begin
      frame_seen_r <= frame_seen_r;
      frame_cnt_r  <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Directed bench for vga_sync_gen using a reduced raster (25x12 totals) so a
// full frame is 300 cycles. H sync active-high, V sync active-low. A bench
// model predicts each registered output set when en is driven; the expectation
// is queued and compared after the next clock edge.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int HP = 16, HF = 2, HS = 3, HB = 4;
  localparam int VP = 6,  VF = 1, VS = 2, VB = 3;
  localparam int HT = 25;
  localparam int VT = 12;
  localparam int FRAME = HT * VT;
  localparam int CB = 5;

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [CB-1:0] px;
    logic [CB-1:0] py;
    logic          ls;
    logic          fs;
    logic [7:0]    fc;
  } exp_t;

  logic          clk_pll = 1'b0;
  logic          rst;
  logic          en;
  logic          hsync, vsync, active, line_start, frame_start;
  logic [CB-1:0] pixel_x, pixel_y;
  logic [7:0]    frame_cnt;

  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   m_h, m_v;
  logic m_started;
  logic [7:0] m_fc;
  exp_t last_e;
  exp_t reset_e;
  exp_t sb_q[$];
  int   fs_seen, hs_seen, vs_low_seen;

  vga_sync_gen #(
    .H_PIXELS(HP), .H_FRONTPORCH(HF), .H_SYNCTIME(HS), .H_BACKPORCH(HB),
    .V_LINES(VP),  .V_FRONTPORCH(VF), .V_SYNCTIME(VS), .V_BACKPORCH(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CNT_BITS(CB)
  ) dut (
    .clk_pll(clk_pll), .rst(rst), .en(en),
    .hsync(hsync), .vsync(vsync), .active(active),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk_pll = ~clk_pll;

  function automatic exp_t observed();
    exp_t o;
    o.hsync  = hsync;
    o.vsync  = vsync;
    o.active = active;
    o.px     = pixel_x;
    o.py     = pixel_y;
    o.ls     = line_start;
    o.fs     = frame_start;
    o.fc     = frame_cnt;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_h       = 0;
    m_v       = 0;
    m_started = 1'b0;
    m_fc      = 8'd0;
    last_e    = reset_e;
  endtask

  // Drive one cycle of en, queue the predicted outputs, then compare after the edge.
  task automatic step(input logic en_v);
    exp_t e;
    exp_t got;
    exp_t want;
    en = en_v;
    if (en_v) begin
      e.px     = CB'(m_h);
      e.py     = CB'(m_v);
      e.active = (m_h < HP) && (m_v < VP);
      e.hsync  = (m_h >= HP + HF) && (m_h <= HP + HF + HS - 1);
      e.vsync  = !((m_v >= VP + VF) && (m_v <= VP + VF + VS - 1));
      e.ls     = (m_h == 0);
      e.fs     = (m_h == 0) && (m_v == 0);
      if (e.fs) begin
        if (m_started) m_fc = m_fc + 8'd1;
        m_started = 1'b1;
      end
`ifdef VGA_SYNC_FRAME_CNT_EN
      e.fc = m_fc;
`else
      e.fc = 8'd0;
`endif
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end else begin
      e    = last_e;
      e.ls = 1'b0;
      e.fs = 1'b0;
    end
    last_e = e;
    sb_q.push_back(e);
    @(posedge clk_pll);
    #1;
    got  = observed();
    want = sb_q.pop_front();
    check("cycle", 32'(got), 32'(want));
    fs_seen     += int'(frame_start);
    hs_seen     += int'(hsync);
    vs_low_seen += int'(!vsync);
  endtask

  initial begin
    bit found;
    reset_e = '{hsync: 1'b0, vsync: 1'b1, active: 1'b0, px: '0, py: '0,
                ls: 1'b0, fs: 1'b0, fc: 8'd0};
    rst = 1'b0;
    en  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_pll);
    #1;
    check("reset_state", 32'(observed()), 32'(reset_e));
    rst = 1'b1;

    // Three full frames with en held high.
    fs_seen = 0; hs_seen = 0; vs_low_seen = 0;
    repeat (3 * FRAME) step(1'b1);
    check("frame_starts_3", 32'(fs_seen), 32'd3);
    check("hsync_cycles", 32'(hs_seen), 32'(3 * VT * HS));
    check("vsync_cycles", 32'(vs_low_seen), 32'(3 * VS * HT));

    // Enable pattern 1,0,0,1 and a random enable stretch.
    repeat (20) begin
      step(1'b1); step(1'b0); step(1'b0); step(1'b1);
    end
    repeat (200) step(1'($urandom_range(0, 1)));

    // Walk to (10,3) and pull reset asynchronously mid-frame.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(1'b1);
      if ((last_e.px == CB'(10)) && (last_e.py == CB'(3))) found = 1'b1;
    end
    check("reach_mid_frame", 32'(found), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 32'(observed()), 32'(reset_e));
    @(posedge clk_pll);
    #1;
    check("reset_hold", 32'(observed()), 32'(reset_e));
    rst = 1'b1;
    model_reset();

    // Restart from (0,0) and run two more frames.
    fs_seen = 0;
    repeat (2 * FRAME) step(1'b1);
    check("frame_starts_2", 32'(fs_seen), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
